regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the integer register file. It shares the file's single write port between two writeback sources, ALU (port 0) and load unit (port 1), using valid/ready handshakes and round-robin priority. It drives the write port from registered outputs. It optionally tracks pending writes per register so the issue stage can detect RAW hazards. It sits between the execute/memory writeback stages and the register file's `wen`/`waddr`/`wdata` inputs.

## Interface
- `N`, 32, number of architectural registers (power of two, ≥2)
- `W`, 32, data width
- `AW`, `$clog2(N)`, derived address width (localparam)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  ALU writeback request
- `req0_addr`  in  AW  destination register
- `req0_data`  in  W  write data
- `req0_ready`  out  1  grant to port 0 (combinational)
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as port 0, for the load unit
- `rf_wen`  out  1  registered write enable to register file
- `rf_waddr`  out  AW  registered write address
- `rf_wdata`  out  W  registered write data
- `iss_valid`  in  1  issue stage marks `iss_addr` pending (scoreboard only)
- `iss_addr`  in  AW  destination of issued instruction
- `q_addr1`, `q_addr2`  in  AW  source-operand query addresses
- `q_busy1`, `q_busy2`  out  1  pending-write flags for the queried registers (combinational)

## Operation
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Priority register `prio` (1 bit): reset 0, meaning port 0 is preferred.
- Grant rules:
  - Only one port valid: that port is granted.
  - Both ports valid: port `prio` is granted.
  - Neither valid: no grant.
  - `reqN_ready = grant_N & ~reset`. A handshake occurs when valid & ready.
- After any handshake on port i, `prio <= 1-i`. With no handshake, `prio` holds.
- A handshake on port i loads `rf_waddr`/`rf_wdata` with that port's addr/data.
- `rf_wen <= 1` only if addr ≠ 0. A write to x0 completes the handshake but produces `rf_wen=0`.
- With no handshake, `rf_wen <= 0`; `rf_waddr`/`rf_wdata` hold.
- At most one grant per cycle, so throughput is one write per cycle. The losing port stalls and must hold its valid/addr/data stable until granted.
- Scoreboard: a `busy[N]` bit vector.
  - Set: `iss_valid` with `iss_addr` ≠ 0 sets `busy[iss_addr]`.
  - Clear: `rf_wen` clears `busy[rf_waddr]`, at the same edge the register file captures the data.
  - Set and clear of the same register in the same cycle: set wins (new producer issued).
  - `busy[0]` is constant 0.
  - `q_busyK = busy[q_addrK]`.
- Writes to a register not marked busy are legal and do not change `busy`.

## Timing
- Reset values: `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `prio=0`, `busy` all 0. `req0_ready=req1_ready=0` while `reset` is high.
- Latency: handshake in cycle T → `rf_wen=1` in cycle T+1 → data is readable from the register file in cycle T+2. `q_busy` for that register drops in T+2.
- Reset mid-operation: a write registered but not yet committed is dropped (`rf_wen=0` the cycle after reset is sampled). The scoreboard and `prio` clear. Requesters must re-present.
- Back-to-back writes to the same address from alternating ports commit in grant order, one per cycle.
- `req*_ready` depends combinationally on both valids. Requesters must not make valid depend on ready.

## Configuration
- `REGFILE_ARB_SCOREBOARD_EN`:
  - Defined: the scoreboard is built as described.
  - Undefined: no `busy` state, `iss_*` inputs are ignored, and `q_busy1`/`q_busy2` are tied to 0. Arbitration and write-port behaviour are identical in both builds.

## Test plan
- Reset then idle: assert `reset` 2 cycles → all outputs 0, readies 0. Release with no valids → `rf_wen` stays 0.
- Single port: `req1_valid`, addr 5, data 0xDEADBEEF, port 0 idle → `req1_ready=1` same cycle. Next cycle `rf_wen=1`, `rf_waddr=5`, `rf_wdata=0xDEADBEEF`. Then `prio=0`.
- Contention: both valid for 4 cycles (port 0 addr 1/data 0x11, port 1 addr 2/data 0x22, each deasserting once served then re-asserting) → grants 0,1,0,1. `rf_waddr` sequence 1,2,1,2, each one cycle after its grant.
- x0 write: `req0_valid` addr 0, data 0xFFFF → `req0_ready=1`, next cycle `rf_wen=0`. `prio` still flips to 1.
- Scoreboard (macro defined): `iss_valid` addr 7 → `q_busy1=1` for `q_addr1=7`. Write addr 7 granted at T → `q_busy1=1` at T+1, 0 at T+2. Same-cycle issue and commit of addr 7 → stays 1. Macro undefined → `q_busy*` always 0.
- Reset mid-write: grant addr 3 at T, `reset` high at T+1 → `rf_wen=0` at T+2, `busy` all clear, `prio=0`.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU (port 0) and
// the load unit (port 1). Round-robin priority picks between simultaneous
// requests, and the write port is driven from registers. An optional
// scoreboard tracks pending writes so that issue can detect RAW hazards.
//
// Build option: define REGFILE_ARB_SCOREBOARD_EN to include the per-register
// busy scoreboard. When it is undefined, q_busy1/q_busy2 are tied to 0 and the
// iss_* inputs are ignored.
module regfile_wb_arbiter #(
    parameter  int N  = 32,
    parameter  int W  = 32,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [W-1:0]  rf_wdata,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] q_addr1,
    input  logic [AW-1:0] q_addr2,
    output logic          q_busy1,
    output logic          q_busy2
);

    // prio_reg names the port that wins when both request (0 = ALU).
    logic          prio_reg;
    logic          prio_next;
    logic          rf_wen_reg;
    logic          rf_wen_next;
    logic [AW-1:0] rf_waddr_reg;
    logic [AW-1:0] rf_waddr_next;
    logic [W-1:0]  rf_wdata_reg;
    logic [W-1:0]  rf_wdata_next;

    logic grant0;
    logic grant1;
    logic hs0;
    logic hs1;

    // Grant selection: a lone requester always wins, a tie goes to prio_reg.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio_reg);
        grant1 = req1_valid & (~req0_valid |  prio_reg);
    end

    // Readies are forced low while reset is held so nothing is accepted.
    assign req0_ready = grant0 & ~reset;
    assign req1_ready = grant1 & ~reset;
    assign hs0        = req0_valid & req0_ready;
    assign hs1        = req1_valid & req1_ready;

    // Next write-port state and priority; writes to x0 handshake but never enable.
    always_comb begin
        prio_next     = prio_reg;
        rf_wen_next   = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;
        if (hs0) begin
            prio_next     = 1'b1;
            rf_wen_next   = |req0_addr;
            rf_waddr_next = req0_addr;
            rf_wdata_next = req0_data;
        end else if (hs1) begin
            prio_next     = 1'b0;
            rf_wen_next   = |req1_addr;
            rf_waddr_next = req1_addr;
            rf_wdata_next = req1_data;
        end
    end

    // Write-port and priority registers; reset drops any uncommitted write.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg     <= 1'b0;
            rf_wen_reg   <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            prio_reg     <= prio_next;
            rf_wen_reg   <= rf_wen_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    assign rf_wen   = rf_wen_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    logic [N-1:0] busy_reg;
    logic [N-1:0] busy_next;

    // x0 can never be pending.
    assign busy_next[0] = 1'b0;

    // Per register: a new issue sets the bit and beats a same-cycle commit.
    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_busy
            assign busy_next[gi] = (iss_valid && (iss_addr == AW'(gi))) ? 1'b1 :
                                   (rf_wen_reg && (rf_waddr_reg == AW'(gi))) ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    // Scoreboard register; cleared on reset along with the write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign q_busy1 = busy_reg[q_addr1];
    assign q_busy2 = busy_reg[q_addr2];
`else
    logic unused_sb_inputs;

    assign unused_sb_inputs = ^{iss_valid, iss_addr, q_addr1, q_addr2};
    assign q_busy1          = 1'b0;
    assign q_busy2          = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Vector table for arbitration/write-port behaviour, hand sequences for the
// scoreboard and reset-mid-write corners, then randomized traffic checked
// against a rule-level reference model. Honors REGFILE_ARB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        iss_valid;
    logic [4:0]  iss_addr, q_addr1, q_addr2;
    logic        q_busy1, q_busy2;

    int tests = 0;
    int fails = 0;

    regfile_wb_arbiter #(.N(32), .W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[11];

    // Reference state for the random phase.
    int          pref_m;
    logic        wen_m;
    logic [4:0]  waddr_m;
    logic [31:0] wdata_m;
    bit          busy_m[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Which port the rules grant: lone requester wins, tie goes to the preferred port.
    function automatic int winner(input bit v0, input bit v1, input int pref);
        if (v0 && v1) return pref;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    initial begin
        int g;
        bit rst;

        vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[3]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        vecs[4]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b1, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       1'b0, 1'b1, 1'b1, 5'd2, 32'h22};
        vecs[6]  = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF};
        vecs[7]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h99,       1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd9, 32'h99};
        vecs[9]  = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd4, 32'h44};
        vecs[10] = '{1'b1, 5'd6, 32'h66,       1'b1, 5'd7, 32'h77,       1'b0, 1'b1, 1'b1, 5'd7, 32'h77};

        // Reset held two cycles with both ports requesting: nothing granted, outputs 0.
        reset = 1'b1;
        iss_valid = 1'b0; iss_addr = 5'd0; q_addr1 = 5'd0; q_addr2 = 5'd0;
        drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
        for (int c = 0; c < 2; c++) begin
            #3;
            chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
            chk("rst_wen", {31'd0, rf_wen}, 32'd0);
            chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
            chk("rst_wdata", rf_wdata, 32'd0);
            $display("[TB] reset cycle %0d", c);
        end
        reset = 1'b0;

        // Table: one vector per cycle, readies checked before the edge, write port after.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #3;
            chk($sformatf("vec%0d_ready0", i), {31'd0, req0_ready}, {31'd0, vecs[i].r0});
            chk($sformatf("vec%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vecs[i].r1});
            tick();
            chk($sformatf("vec%0d_wen", i), {31'd0, rf_wen}, {31'd0, vecs[i].wen});
            chk($sformatf("vec%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].waddr});
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wdata);
            $display("[TB] vec %0d v0=%0d v1=%0d -> wen=%0d waddr=%0d", i, vecs[i].v0, vecs[i].v1, rf_wen, rf_waddr);
        end

        // Scoreboard: issue, commit latency, and set-beats-clear.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        q_addr1 = 5'd7; q_addr2 = 5'd0;
        tick();
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        chk("sb_issue_busy", {31'd0, q_busy1}, {31'd0, SB});
        iss_valid = 1'b0;
        drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        #3;
        chk("sb_T_ready0", {31'd0, req0_ready}, 32'd1);
        chk("sb_T_busy", {31'd0, q_busy1}, {31'd0, SB});
        tick();
        chk("sb_T1_wen", {31'd0, rf_wen}, 32'd1);
        chk("sb_T1_busy", {31'd0, q_busy1}, {31'd0, SB});
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("sb_T2_busy", {31'd0, q_busy1}, 32'd0);
        chk("sb_x0_busy", {31'd0, q_busy2}, 32'd0);
        $display("[TB] scoreboard commit sequence done");
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        iss_valid = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h78);
        tick();
        chk("sb_same_wen", {31'd0, rf_wen}, 32'd1);
        chk("sb_same_waddr", {27'd0, rf_waddr}, 32'd7);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        chk("sb_same_cycle_busy", {31'd0, q_busy1}, {31'd0, SB});
        iss_valid = 1'b0;
        tick();
        chk("sb_same_hold_busy", {31'd0, q_busy1}, {31'd0, SB});
        $display("[TB] scoreboard set-wins sequence done");

        // Reset with a write registered but not yet committed.
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        iss_valid = 1'b0;
        q_addr1 = 5'd3; q_addr2 = 5'd7;
        drive(1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'h0);
        tick();
        chk("rmw_T1_wen", {31'd0, rf_wen}, 32'd1);
        chk("rmw_T1_busy3", {31'd0, q_busy1}, {31'd0, SB});
        reset = 1'b1;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        #3;
        chk("rmw_rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rmw_rst_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("rmw_T2_wen", {31'd0, rf_wen}, 32'd0);
        chk("rmw_T2_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rmw_T2_busy3", {31'd0, q_busy1}, 32'd0);
        chk("rmw_T2_busy7", {31'd0, q_busy2}, 32'd0);
        reset = 1'b0;
        #3;
        chk("rmw_prio_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rmw_prio_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("rmw_after_waddr", {27'd0, rf_waddr}, 32'd1);
        $display("[TB] reset mid-write sequence done");

        // Random traffic against the rule-level model; first cycle forces a reset.
        pref_m = 0; wen_m = 1'b0; waddr_m = 5'd0; wdata_m = 32'd0;
        for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst = (i == 0) || ($urandom_range(0, 39) == 0);
            reset = rst;
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            iss_valid = $urandom_range(0, 1) != 0;
            iss_addr  = 5'($urandom_range(0, 7));
            q_addr1   = 5'($urandom_range(0, 7));
            q_addr2   = 5'($urandom_range(0, 7));
            g = rst ? -1 : winner(req0_valid, req1_valid, pref_m);
            #3;
            chk("rnd_ready0", {31'd0, req0_ready}, {31'd0, g == 0});
            chk("rnd_ready1", {31'd0, req1_ready}, {31'd0, g == 1});
            if (i > 0) begin
                chk("rnd_busy1", {31'd0, q_busy1}, {31'd0, SB & busy_m[q_addr1]});
                chk("rnd_busy2", {31'd0, q_busy2}, {31'd0, SB & busy_m[q_addr2]});
            end
            tick();
            if (rst) begin
                pref_m = 0; wen_m = 1'b0; waddr_m = 5'd0; wdata_m = 32'd0;
                for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
            end else begin
                if (wen_m) busy_m[waddr_m] = 1'b0;
                if (iss_valid && iss_addr != 5'd0) busy_m[iss_addr] = 1'b1;
                if (g == 0) begin
                    wen_m = (req0_addr != 5'd0); waddr_m = req0_addr; wdata_m = req0_data; pref_m = 1;
                end else if (g == 1) begin
                    wen_m = (req1_addr != 5'd0); waddr_m = req1_addr; wdata_m = req1_data; pref_m = 0;
                end else begin
                    wen_m = 1'b0;
                end
            end
            chk("rnd_wen", {31'd0, rf_wen}, {31'd0, wen_m});
            chk("rnd_waddr", {27'd0, rf_waddr}, {27'd0, waddr_m});
            chk("rnd_wdata", rf_wdata, wdata_m);
            $display("[TB] rnd %0d rst=%0d grant=%0d wen=%0d waddr=%0d", i, rst, g, rf_wen, rf_waddr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
